// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the serial subtractor and other val/rdy iterative units:
// FSM state encodings and counter sizing.
package serial_subtractor_pkg;

  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_CALC = 2'd1;
  localparam logic [1:0] STATE_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = STATE_IDLE,
    CALC = STATE_CALC,
    DONE = STATE_DONE
  } state_t;

  // One extra bit so a width of 1 still gets a usable counter.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result val/rdy bundle for the serial subtractor.
// The master drives operands and consumes the result; the slave is the unit.
interface serial_subtractor_if #(
  parameter int nbits = 8
);
  logic             in_val;
  logic             in_rdy;
  logic [nbits-1:0] in0;
  logic [nbits-1:0] in1;
  logic             out_val;
  logic             out_rdy;
  logic [nbits-1:0] diff;
  logic             bout;

  modport master (
    output in_val, in0, in1, out_rdy,
    input  in_rdy, out_val, diff, bout
  );

  modport slave (
    input  in_val, in0, in1, out_rdy,
    output in_rdy, out_val, diff, bout
  );
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// Gate-level full-subtractor cell: d = a - b - bin, with borrow-out.
// Built from primitives in the same manner as the full-adder cells.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  logic w_axb;
  logic w_na;
  logic w_nxb;
  logic w_t1;
  logic w_t2;

  xor g_x1 (w_axb, a, b);
  xor g_x2 (d, w_axb, bin);
  not g_n1 (w_na, a);
  and g_a1 (w_t1, w_na, b);
  // A borrow-in propagates only when the two operand bits are equal.
  not g_n2 (w_nxb, w_axb);
  and g_a2 (w_t2, w_nxb, bin);
  or  g_o1 (bout, w_t1, w_t2);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = in0 - in1 resolved LSB-first, one bit per cycle,
// through a single full-subtractor cell and a registered borrow.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int nbits = 8
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave bus
);
  localparam int CW = cnt_width(nbits);

  state_t           r_state;
  logic [nbits-1:0] r_a;
  logic [nbits-1:0] r_b;
  logic [nbits-1:0] r_res;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic [nbits-1:0] r_diff;
  logic             r_bout;
  logic             r_out_val;

  logic             w_d;
  logic             w_bout;
  logic [nbits-1:0] w_res_next;

  full_subtractor u_fs (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_br),
    .d    (w_d),
    .bout (w_bout)
  );

  // New difference bit enters at the MSB so the LSB lands at bit 0 after nbits shifts.
  assign w_res_next = (r_res >> 1) | (nbits'(w_d) << (nbits - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_res     <= '0;
      r_br      <= 1'b0;
      r_cnt     <= '0;
      r_diff    <= '0;
      r_bout    <= 1'b0;
      r_out_val <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_val) begin
            r_a     <= bus.in0;
            r_b     <= bus.in1;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_state <= CALC;
          end
        end
        CALC: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_br  <= w_bout;
          r_res <= w_res_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(nbits - 1)) begin
            r_diff    <= w_res_next;
            r_bout    <= w_bout;
            r_out_val <= 1'b1;
            r_state   <= DONE;
          end
        end
        DONE: begin
          if (bus.out_rdy) begin
            r_out_val <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_rdy  = (r_state == IDLE) && !rst;
  assign bus.out_val = r_out_val;
  assign bus.diff    = r_diff;
  assign bus.bout    = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: an 8-bit and a 1-bit instance driven in turn.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst8;
  logic rst1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.nbits(8)) b8 ();
  serial_subtractor_if #(.nbits(1)) b1 ();

  serial_subtractor #(.nbits(8)) u_dut8 (.clk(clk), .rst(rst8), .bus(b8));
  serial_subtractor #(.nbits(1)) u_dut1 (.clk(clk), .rst(rst1), .bus(b1));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept one 8-bit operation and check latency and result; leaves the unit in DONE.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ed,
                      input logic eb, input string tag);
    b8.in0    = a;
    b8.in1    = b;
    b8.in_val = 1'b1;
    step();
    b8.in_val = 1'b0;
    chk({tag, "_busy_rdy"}, b8.in_rdy, 0);
    for (int i = 1; i < 8; i++) begin
      step();
      chk($sformatf("%s_early_val%0d", tag, i), b8.out_val, 0);
    end
    step();
    chk({tag, "_val"}, b8.out_val, 1);
    chk({tag, "_diff"}, b8.diff, ed);
    chk({tag, "_bout"}, b8.bout, eb);
    $display("op %s: %02h - %02h -> diff=%02h bout=%0d", tag, a, b, b8.diff, b8.bout);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst8 = 1'b1;
    rst1 = 1'b1;
    b8.in_val = 1'b0; b8.in0 = '0; b8.in1 = '0; b8.out_rdy = 1'b1;
    b1.in_val = 1'b0; b1.in0 = '0; b1.in1 = '0; b1.out_rdy = 1'b1;
    step();
    step();
    chk("rst_in_rdy", b8.in_rdy, 0);
    chk("rst_out_val", b8.out_val, 0);
    chk("rst_diff", b8.diff, 0);
    chk("rst_bout", b8.bout, 0);
    rst8 = 1'b0;
    #1;
    chk("post_rst_in_rdy", b8.in_rdy, 1);

    // Basic subtraction with latency check
    run8(8'h35, 8'h12, 8'h23, 1'b0, "basic");
    step();
    chk("basic_idle_rdy", b8.in_rdy, 1);
    chk("basic_idle_val", b8.out_val, 0);

    run8(8'h00, 8'h01, 8'hFF, 1'b1, "underflow");
    step();
    run8(8'h80, 8'h80, 8'h00, 1'b0, "equal");
    step();
    run8(8'h5A, 8'h00, 8'h5A, 1'b0, "sub_zero");
    step();

    // Backpressure: result must hold while out_rdy is low
    b8.out_rdy = 1'b0;
    run8(8'hA0, 8'h0F, 8'h91, 1'b0, "bp");
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("bp_hold_val%0d", i), b8.out_val, 1);
      chk($sformatf("bp_hold_diff%0d", i), b8.diff, 8'h91);
      chk($sformatf("bp_hold_bout%0d", i), b8.bout, 0);
      chk($sformatf("bp_hold_rdy%0d", i), b8.in_rdy, 0);
    end
    b8.out_rdy = 1'b1;
    step();
    chk("bp_release_rdy", b8.in_rdy, 1);
    chk("bp_release_val", b8.out_val, 0);

    // Operands presented while busy must be ignored
    b8.in0 = 8'h10; b8.in1 = 8'h01; b8.in_val = 1'b1;
    step();
    b8.in0 = 8'hFF; b8.in1 = 8'h00;
    for (int i = 0; i < 8; i++) step();
    b8.in_val = 1'b0;
    chk("ignore_val", b8.out_val, 1);
    chk("ignore_diff", b8.diff, 8'h0F);
    chk("ignore_bout", b8.bout, 0);
    $display("op ignore: 10 - 01 -> diff=%02h bout=%0d", b8.diff, b8.bout);
    step();

    // Reset in the third CALC cycle discards the operation
    b8.in0 = 8'h33; b8.in1 = 8'h11; b8.in_val = 1'b1;
    step();
    b8.in_val = 1'b0;
    step();
    step();
    rst8 = 1'b1;
    step();
    rst8 = 1'b0;
    #1;
    chk("midrst_rdy", b8.in_rdy, 1);
    chk("midrst_val", b8.out_val, 0);
    chk("midrst_diff", b8.diff, 0);
    chk("midrst_bout", b8.bout, 0);
    step();
    chk("midrst_no_spurious", b8.out_val, 0);
    run8(8'h05, 8'h07, 8'hFE, 1'b1, "after_rst");
    step();

    // 1-bit instance: rst together with in_val accepts nothing
    b1.in0 = 1'b0; b1.in1 = 1'b1; b1.in_val = 1'b1;
    step();
    rst1 = 1'b0;
    b1.in_val = 1'b0;
    #1;
    chk("n1_rst_rdy", b1.in_rdy, 1);
    step();
    step();
    chk("n1_rst_no_val", b1.out_val, 0);
    chk("n1_rst_still_idle", b1.in_rdy, 1);

    b1.in_val = 1'b1;
    step();
    b1.in_val = 1'b0;
    chk("n1_busy_rdy", b1.in_rdy, 0);
    chk("n1_early_val", b1.out_val, 0);
    step();
    chk("n1_val", b1.out_val, 1);
    chk("n1_diff", b1.diff, 1);
    chk("n1_bout", b1.bout, 1);
    $display("op n1: 0 - 1 -> diff=%0d bout=%0d", b1.diff, b1.bout);
    step();
    chk("n1_idle_rdy", b1.in_rdy, 1);
    chk("n1_idle_val", b1.out_val, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor: diff = in0 - in1, with borrow-out.
- Inverse-direction companion to the team's gate-level ripple adders. Instead of parallel carry logic, it resolves one bit per cycle through a single full-subtractor cell and a registered borrow.
- Sits behind a val/rdy input interface and a val/rdy output interface, so it can drop into datapath labs as a multi-cycle functional unit.

Parameters:
- nbits, 8, operand and result width; legal range 1..32.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_val  input  1  operands valid.
- in_rdy  output  1  unit idle and able to accept operands.
- in0  input  nbits  minuend.
- in1  input  nbits  subtrahend.
- out_val  output  1  result valid.
- out_rdy  input  1  consumer ready for the result.
- diff  output  nbits  in0 - in1, modulo 2^nbits.
- bout  output  1  final borrow; 1 iff in0 < in1 (unsigned).

Behaviour:
- Reset: synchronous, active-high. In the cycle after rst is sampled high:
  - state = IDLE;
  - diff = 0, bout = 0, out_val = 0;
  - all internal shift registers and the counter = 0.
  - in_rdy is forced to 0 while rst is high.
- FSM has three states: IDLE, CALC, DONE.
  - IDLE: in_rdy = 1, out_val = 0. When in_val && in_rdy at an edge:
    - latch in0 into shift register A and in1 into shift register B;
    - clear the borrow register and the counter;
    - go to CALC.
  - CALC: in_rdy = 0, out_val = 0. Each cycle:
    - d = A[0] ^ B[0] ^ br;
    - br_next = (~A[0] & B[0]) | (~(A[0] ^ B[0]) & br);
    - A and B shift right by 1;
    - d shifts into the MSB of the result register R, which shifts right;
    - counter increments.
    - When counter == nbits-1 at an edge, go to DONE.
  - DONE: out_val = 1, diff = R, bout = br; all are held stable until out_val && out_rdy. At that edge go to IDLE.
- Counter width is $clog2(nbits)+1, so nbits = 1 is legal.
- Latency: operands accepted at the edge ending cycle T; CALC occupies cycles T+1 .. T+nbits; out_val is first high in cycle T+nbits+1.
- Throughput: one operation per nbits+2 cycles at best. There is no accept in the same cycle as the output handshake, because in_rdy = 0 in DONE.
- Input ignores:
  - in_val while busy (CALC or DONE) is ignored; operands are not sampled.
  - Changes to in0/in1 after acceptance have no effect.
- out_rdy low in DONE is backpressure: stay in DONE indefinitely with outputs unchanged.
- Reset mid-operation (CALC or DONE): the partial result is discarded. Next cycle is IDLE with all reset values; no spurious out_val.
- Simultaneous rst and in_val: rst wins, nothing is accepted.
- Edge operands:
  - in0 == in1 gives diff = 0, bout = 0.
  - in1 == 0 gives diff = in0, bout = 0.
  - Wrap-around is modulo 2^nbits.

Decomposition:
- Shared include file: state encoding constants (STATE_IDLE = 2'd0, STATE_CALC = 2'd1, STATE_DONE = 2'd2). These are reused by other val/rdy iterative units.
- One sub-module, full_subtractor: inputs a, b, bin; outputs d, bout. It is built from xor/and/or gate primitives in the same style as the team's full-adder cells, and instantiated once for the serial bit slice.
- Top level holds the FSM, counter, and shift/borrow registers.

Test Plan:
- nbits=8, in0=0x35, in1=0x12, out_rdy=1 -> out_val high exactly 9 cycles after acceptance; diff=0x23, bout=0.
- in0=0x00, in1=0x01 -> diff=0xFF, bout=1. Then in0=0x80, in1=0x80 -> diff=0x00, bout=0.
- Accept 0xA0 - 0x0F with out_rdy=0 for 5 cycles after out_val rises -> diff=0x91, bout=0 stable throughout and in_rdy=0. out_rdy=1 -> IDLE next cycle, in_rdy=1.
- Accept 0x10 - 0x01; during CALC drive in_val=1 with in0=0xFF, in1=0x00 -> ignored; result diff=0x0F, bout=0.
- Accept operands, assert rst in the 3rd CALC cycle -> next cycle in_rdy=1 (rst low), out_val=0, diff=0, bout=0. A new op 0x05 - 0x07 then gives diff=0xFE, bout=1.
- nbits=1 instance: 0 - 1 -> diff=1, bout=1 after 2 cycles; rst and in_val asserted together -> no acceptance.
